// File: rtl/limber_gnrl_pkg.sv
// limber_gnrl arithmetic library shared package.
// FSM state encoding and default operand widths.
package limber_gnrl_pkg;

  localparam int DEF_DW1 = 32;
  localparam int DEF_DW2 = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/limber_gnrl_mul_step.sv
// One radix-2 add-shift iteration of the shift-add multiplier.
// Pure combinational; P is {acc, remaining multiplier bits}.
module limber_gnrl_mul_step #(
  parameter int DW1 = 32,
  parameter int DW2 = 32
) (
  input  logic [DW1+DW2:0] p_i,
  input  logic [DW1-1:0]   mcand_i,
  output logic [DW1+DW2:0] p_o
);

  localparam int DW = DW1 + DW2;

  logic [DW1:0] sum;

  assign sum = p_i[DW:DW2] + (p_i[0] ? {1'b0, mcand_i} : '0);
  assign p_o = {1'b0, sum, p_i[DW2-1:1]};

endmodule

// File: rtl/limber_gnrl_mul.sv
// Sequential radix-2 shift-add multiplier (IDLE/RUN/DONE FSM).
// Define LIMBER_GNRL_MUL_SIGNED_EN for two's-complement operands.
module limber_gnrl_mul
  import limber_gnrl_pkg::*;
#(
  parameter int DW1 = DEF_DW1,
  parameter int DW2 = DEF_DW2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clr,
  input  logic [DW1-1:0]     i_a,
  input  logic [DW2-1:0]     i_b,
  input  logic               i_valid,
  output logic               o_ready,
  output logic [DW1+DW2-1:0] o_prod,
  output logic               o_valid
);

  localparam int DW = DW1 + DW2;
  localparam int CW = $clog2(DW2 + 1);
  localparam logic [CW-1:0] LAST = CW'(DW2 - 1);

  mul_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW:0]   p_q, p_d, p_nxt;
  logic [DW1-1:0] mcand_q, mcand_d;
  logic [DW-1:0] prod_q, prod_d;
  logic [DW1-1:0] a_mag;
  logic [DW2-1:0] b_mag;
  logic [DW-1:0] res;

`ifdef LIMBER_GNRL_MUL_SIGNED_EN
  logic neg_q, neg_d;

  // Most-negative input maps to its unsigned magnitude 2^(DWx-1).
  assign a_mag = i_a[DW1-1] ? -i_a : i_a;
  assign b_mag = i_b[DW2-1] ? -i_b : i_b;
  assign res   = neg_q ? -p_nxt[DW-1:0] : p_nxt[DW-1:0];
`else
  assign a_mag = i_a;
  assign b_mag = i_b;
  assign res   = p_nxt[DW-1:0];
`endif

  limber_gnrl_mul_step #(
    .DW1(DW1),
    .DW2(DW2)
  ) u_step (
    .p_i    (p_q),
    .mcand_i(mcand_q),
    .p_o    (p_nxt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
`ifdef LIMBER_GNRL_MUL_SIGNED_EN
    neg_d   = neg_q;
`endif
    if (i_clr) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_valid) begin
            p_d     = {{(DW1+1){1'b0}}, b_mag};
            mcand_d = a_mag;
            cnt_d   = '0;
            state_d = RUN;
`ifdef LIMBER_GNRL_MUL_SIGNED_EN
            neg_d   = i_a[DW1-1] ^ i_b[DW2-1];
`endif
          end
        end
        RUN: begin
          p_d   = p_nxt;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            prod_d  = res;
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
`ifdef LIMBER_GNRL_MUL_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
`ifdef LIMBER_GNRL_MUL_SIGNED_EN
      neg_q   <= neg_d;
`endif
    end
  end

  assign o_ready = (state_q == IDLE);
  assign o_valid = (state_q == DONE) && !i_clr;
  assign o_prod  = prod_q;

endmodule

// File: tb/tb_limber_gnrl_mul.sv
// Self-checking bench for limber_gnrl_mul at DW1=DW2=8.
// Table vectors, random ops vs. arithmetic model, clear/reset sequences.
module tb_limber_gnrl_mul;

  localparam int DW1 = 8;
  localparam int DW2 = 8;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_clr;
  logic        i_valid;
  logic [7:0]  i_a;
  logic [7:0]  i_b;
  logic        o_ready;
  logic        o_valid;
  logic [15:0] o_prod;

  int total = 0;
  int bad = 0;

  always #5 i_clk = ~i_clk;

  limber_gnrl_mul #(
    .DW1(DW1),
    .DW2(DW2)
  ) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (i_clr),
    .i_a    (i_a),
    .i_b    (i_b),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .o_prod (o_prod),
    .o_valid(o_valid)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] a,
                                          input logic [7:0] b);
    int x;
    int y;
`ifdef LIMBER_GNRL_MUL_SIGNED_EN
    x = $signed(a);
    y = $signed(b);
`else
    x = int'(a);
    y = int'(b);
`endif
    return 16'(x * y);
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // lat = number of post-edge samples after the accept edge until o_valid
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] p, output int lat,
                        output int rdy_hi);
    int n;
    n = 0;
    while (!o_ready && n < 40) begin
      tick();
      n++;
    end
    i_a = a;
    i_b = b;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    lat = -1;
    rdy_hi = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (o_valid) begin
        lat = k;
        break;
      end
      if (o_ready) rdy_hi++;
    end
    p = o_prod;
  endtask

  vec_t        vt[10];
  logic [15:0] p;
  logic [15:0] prev;
  logic [15:0] q[$];
  int          lat;
  int          rh;
  int          nres;
  int          last;
  int          cnt;

  initial begin
    vt[0] = '{8'd255, 8'd255, 16'hFE01};
    vt[1] = '{8'd0,   8'd173, 16'h0000};
    vt[2] = '{8'd1,   8'd0,   16'h0000};
    vt[3] = '{8'd13,  8'd11,  16'h008F};
    vt[4] = '{8'd3,   8'd7,   16'h0015};
    vt[5] = '{8'h80,  8'h80,  16'h4000};
`ifdef LIMBER_GNRL_MUL_SIGNED_EN
    vt[0] = '{8'd127, 8'd127, 16'h3F01};
    vt[3] = '{8'd13,  8'd11,  16'h008F};
    vt[6] = '{8'hFD,  8'h05,  16'hFFF1};
    vt[7] = '{8'h7F,  8'h80,  16'hC080};
    vt[8] = '{8'hFF,  8'hFF,  16'h0001};
    vt[9] = '{8'h05,  8'hFD,  16'hFFF1};
`else
    vt[6] = '{8'hFD,  8'h05,  16'h04F1};
    vt[7] = '{8'h7F,  8'h80,  16'h3F80};
    vt[8] = '{8'hFF,  8'h01,  16'h00FF};
    vt[9] = '{8'h05,  8'hFD,  16'h04F1};
`endif

    i_rst = 1'b1;
    i_clr = 1'b0;
    i_valid = 1'b0;
    i_a = '0;
    i_b = '0;
    repeat (2) @(posedge i_clk);
    #2;
    check("rst_valid", o_valid, 0);
    check("rst_prod", o_prod, 0);
    check("rst_ready", o_ready, 1);
    i_rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      run_op(vt[i].a, vt[i].b, p, lat, rh);
      check($sformatf("vec%0d_prod", i), p, vt[i].exp);
      check($sformatf("vec%0d_lat", i), lat, 8);
      check($sformatf("vec%0d_busy", i), rh, 0);
      tick();
      check($sformatf("vec%0d_pulse", i), o_valid, 0);
      check($sformatf("vec%0d_ready", i), o_ready, 1);
    end

    for (int i = 0; i < 25; i++) begin
      logic [7:0] a;
      logic [7:0] b;
      a = 8'($urandom);
      b = 8'($urandom);
      run_op(a, b, p, lat, rh);
      check($sformatf("rnd%0d_prod", i), p, ref_mul(a, b));
    end
    tick();

    // held i_valid: only operands seen while ready are consumed
    nres = 0;
    last = -1;
    i_valid = 1'b1;
    for (int c = 0; c < 45; c++) begin
      i_a = 8'($urandom);
      i_b = 8'($urandom);
      if (o_ready) q.push_back(ref_mul(i_a, i_b));
      tick();
      if (o_valid) begin
        nres++;
        check("stream_queue", q.size() != 0, 1);
        if (q.size() != 0) check("stream_prod", o_prod, q.pop_front());
        if (last >= 0) check("stream_gap", c - last, 10);
        last = c;
      end
    end
    i_valid = 1'b0;
    check("stream_count", nres, 4);
    cnt = 0;
    for (int c = 0; c < 20 && cnt == 0; c++) begin
      tick();
      if (o_valid) begin
        cnt++;
        if (q.size() != 0) check("stream_tail", o_prod, q.pop_front());
      end
    end
    check("stream_tail_seen", cnt, 1);
    tick();

    prev = o_prod;
    i_a = 8'd100;
    i_b = 8'd100;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    repeat (3) tick();
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
    check("clr_ready", o_ready, 1);
    check("clr_valid", o_valid, 0);
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (o_valid) cnt++;
    end
    check("clr_no_result", cnt, 0);
    check("clr_prod_held", o_prod, prev);

    i_a = 8'd9;
    i_b = 8'd9;
    i_clr = 1'b1;
    i_valid = 1'b1;
    tick();
    i_clr = 1'b0;
    i_valid = 1'b0;
    check("clr_beats_valid", o_ready, 1);
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (o_valid) cnt++;
    end
    check("clr_beats_novalid", cnt, 0);

    i_a = 8'd200;
    i_b = 8'd200;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    repeat (3) tick();
    i_rst = 1'b1;
    #1;
    check("midrst_valid", o_valid, 0);
    check("midrst_prod", o_prod, 0);
    check("midrst_ready", o_ready, 1);
    @(posedge i_clk);
    #2;
    i_rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (o_valid) cnt++;
    end
    check("midrst_no_result", cnt, 0);
    run_op(8'd3, 8'd7, p, lat, rh);
    check("post_rst_prod", p, 16'h0015);
    check("post_rst_lat", lat, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
